tpu_wb_engine: RTL and testbench

Parametrised write-back engine for systolic-array results. It accepts a stream of result words from the array and emits each word with its destination scratchpad address. Two layouts are supported: conv order (channel-inner) and matrix order (row-inner). A tile loop is walked on top of either layout. Full valid/ready backpressure on both sides, a base-address offset, zero-dimension error detection and a mid-transfer abort are included. The engine sits between the array output collector and the SRAM write port.

---
 rtl/tpu_wb_engine.sv | 106 ++++++++++
 tb/tb_tpu_wb_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_wb_engine.sv
// tpu_wb_engine: streams array results to scratchpad addresses in conv or matrix order over a tile loop.
module tpu_wb_engine #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [1:0]        cfg_op,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [DIM_W-1:0]  cfg_channel,
   input  logic [DIM_W-1:0]  cfg_row,
   input  logic [DIM_W-1:0]  cfg_tile,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              di_valid,
   output logic              di_ready,
   input  logic [DATA_W-1:0] di_data,
   output logic              do_valid,
   input  logic              do_ready,
   output logic [DATA_W-1:0] do_data,
   output logic [ADDR_W-1:0] do_addr,
   output logic              do_last
);
   typedef enum logic [1:0] {IDLE, CONV, MAT} state_t;
   state_t state, state_nx;
   logic [DIM_W-1:0] c_dim, r_dim, t_dim, ch, r, t;
   logic [ADDR_W-1:0] cr, tile_base, ch_off;
   logic [2*DIM_W-1:0] prod;
   logic last_taken, abort, start, dims_ok, in_hs, out_hs;
   logic ch_w, r_w, is_last, conv, ch_step, r_step, t_step;
   assign cfg_ready = state == IDLE;
   assign busy = state != IDLE;
   assign abort = cfg_valid && cfg_op == 2'b11;
   assign start = cfg_valid && cfg_ready && (cfg_op == 2'b01 || cfg_op == 2'b10);
   assign dims_ok = |c_dim && |r_dim && |t_dim;
   assign di_ready = busy && !last_taken && (!do_valid || do_ready);
   assign in_hs = di_valid && di_ready && !abort;
   assign out_hs = do_valid && do_ready;
   assign prod = c_dim * r_dim;
   assign ch_w = ch == c_dim - DIM_W'(1);
   assign r_w = r == r_dim - DIM_W'(1);
   assign is_last = ch_w && r_w && t == t_dim - DIM_W'(1);
   // conv steps ch every word and r on ch wrap; mat is the mirror image
   assign conv = state == CONV;
   assign ch_step = conv || r_w;
   assign r_step = !conv || ch_w;
   assign t_step = ch_w && r_w;
   always_comb begin
      state_nx = state;
      if (abort)
         state_nx = IDLE;
      else if (start && dims_ok)
         state_nx = cfg_op == 2'b01 ? CONV : MAT;
      else if (out_hs && do_last)
         state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {c_dim, r_dim, t_dim, ch, r, t} <= '0;
         {cr, tile_base, ch_off} <= '0;
         {last_taken, done, err, do_valid, do_last} <= '0;
         do_data <= '0;
         do_addr <= '0;
      end else begin
         done <= out_hs && do_last && !abort;
         err <= start && !dims_ok;
         if (cfg_valid && cfg_ready && cfg_op == 2'b00)
            {c_dim, r_dim, t_dim} <= {cfg_channel, cfg_row, cfg_tile};
         if (abort) begin
            {ch, r, t, ch_off} <= '0;
            {last_taken, do_valid} <= '0;
         end else if (start && dims_ok) begin
            {ch, r, t, ch_off} <= '0;
            last_taken <= 1'b0;
            tile_base <= cfg_base;
            cr <= ADDR_W'(prod);
         end else if (in_hs) begin
            do_valid <= 1'b1;
            do_data <= di_data;
            do_addr <= tile_base + ch_off + ADDR_W'(r);
            do_last <= is_last;
            last_taken <= is_last;
            if (ch_step) begin
               ch <= ch_w ? '0 : ch + DIM_W'(1);
               ch_off <= ch_w ? '0 : ch_off + ADDR_W'(r_dim);
            end
            if (r_step)
               r <= r_w ? '0 : r + DIM_W'(1);
            if (t_step) begin
               t <= t + DIM_W'(1);
               tile_base <= tile_base + cr;
            end
         end else if (out_hs)
            do_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_tpu_wb_engine.sv
// tb_tpu_wb_engine: random and directed stimulus against a queue-based reference of the write-back engine.
module tb_tpu_wb_engine;
   logic clk = 0, rst = 0, cfg_valid = 0, di_valid = 0, do_ready = 0;
   logic [1:0] cfg_op = 0;
   logic [15:0] cfg_base = 0;
   logic [7:0] cfg_channel = 0, cfg_row = 0, cfg_tile = 0;
   logic [31:0] di_data = 0;
   logic cfg_ready, busy, done, err, di_ready, do_valid, do_last;
   logic [31:0] do_data;
   logic [15:0] do_addr;
   int pass_n = 0, tot_n = 0;
   int mc, mr, mt, idx;
   bit m_busy, done_exp, err_exp, prev_stall, prev_abort, s_last;
   logic [31:0] s_data;
   logic [15:0] s_addr;
   logic [15:0] exp_addr[$], q_addr[$], obs[$];
   logic [31:0] q_data[$];
   bit q_last[$];

   tpu_wb_engine dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
      .cfg_base(cfg_base), .cfg_channel(cfg_channel), .cfg_row(cfg_row), .cfg_tile(cfg_tile),
      .busy(busy), .done(done), .err(err), .di_valid(di_valid), .di_ready(di_ready),
      .di_data(di_data), .do_valid(do_valid), .do_ready(do_ready), .do_data(do_data),
      .do_addr(do_addr), .do_last(do_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // expected address sequence straight from base + t*C*R + ch*R + r
   function automatic void build(input bit is_conv, input logic [15:0] b);
      exp_addr.delete();
      for (int tt = 0; tt < mt; tt++)
         for (int o = 0; o < (is_conv ? mr : mc); o++)
            for (int i = 0; i < (is_conv ? mc : mr); i++)
               exp_addr.push_back(b + 16'(tt * mc * mr + (is_conv ? i * mr + o : o * mr + i)));
   endfunction

   task automatic monitor();
      bit ab, nd, ne;
      forever begin
         @(negedge clk);
         if (!rst) begin
            {mc, mr, mt, idx} = '0;
            {m_busy, done_exp, err_exp, prev_stall, prev_abort} = '0;
            exp_addr.delete(); q_addr.delete(); q_data.delete(); q_last.delete();
         end else begin
            ab = cfg_valid && cfg_op == 2'b11;
            nd = 0;
            ne = 0;
            chk("done", done, done_exp);
            chk("err", err, err_exp);
            chk("busy", busy, m_busy);
            chk("cfg_ready", cfg_ready, !m_busy);
            chk("di_ready", di_ready, m_busy && idx < exp_addr.size() && (!do_valid || do_ready));
            if (prev_abort) chk("abort_do_valid", do_valid, 0);
            else if (prev_stall) begin
               chk("stall_valid", do_valid, 1);
               chk("stall_data", do_data, s_data);
               chk("stall_addr", do_addr, s_addr);
               chk("stall_last", do_last, s_last);
            end
            if (do_valid && do_ready) begin
               obs.push_back(do_addr);
               chk("out_expected", q_data.size() != 0, 1);
               if (q_data.size() != 0) begin
                  chk("out_data", do_data, q_data.pop_front());
                  chk("out_addr", do_addr, q_addr.pop_front());
                  chk("out_last", do_last, q_last.pop_front());
               end
               if (do_last) begin
                  nd = !ab;
                  m_busy = 0;
               end
            end
            if (di_valid && di_ready && !ab) begin
               chk("in_in_range", idx < exp_addr.size(), 1);
               if (idx < exp_addr.size()) begin
                  q_data.push_back(di_data);
                  q_addr.push_back(exp_addr[idx]);
                  q_last.push_back(idx == exp_addr.size() - 1);
               end
               idx++;
            end
            if (cfg_valid && cfg_ready && cfg_op == 2'b00) begin
               mc = cfg_channel; mr = cfg_row; mt = cfg_tile;
            end else if (cfg_valid && cfg_ready && cfg_op != 2'b11) begin
               if (mc != 0 && mr != 0 && mt != 0) begin
                  build(cfg_op == 2'b01, cfg_base);
                  idx = 0;
                  m_busy = 1;
               end else ne = 1;
            end
            if (ab) begin
               q_addr.delete(); q_data.delete(); q_last.delete();
               idx = 0;
               m_busy = 0;
            end
            prev_abort = ab;
            prev_stall = do_valid && !do_ready && !ab;
            {s_data, s_addr, s_last} = {do_data, do_addr, do_last};
            done_exp = nd;
            err_exp = ne;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] op, input logic [15:0] b, input int c, input int r, input int t);
      cfg_valid = 1; cfg_op = op; cfg_base = b;
      cfg_channel = 8'(c); cfg_row = 8'(r); cfg_tile = 8'(t);
      tick();
      cfg_valid = 0;
   endtask

   task automatic run(input int vp, input int rp);
      int n = 0;
      while (m_busy && n < 3000) begin
         di_valid = $urandom_range(0, 99) < vp;
         di_data = $urandom;
         do_ready = $urandom_range(0, 99) < rp;
         tick();
         n++;
      end
      chk("transfer_finished", m_busy, 0);
      di_valid = 0;
      do_ready = 1;
      tick();
      tick();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_do_valid"}, do_valid, 0);
      chk({tag, "_do_data"}, do_data, 0);
      chk({tag, "_do_addr"}, do_addr, 0);
      chk({tag, "_do_last"}, do_last, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_di_ready"}, di_ready, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 1);
   endtask

   initial begin
      logic [15:0] e1 [6];
      logic [15:0] ew [4];
      e1 = '{16'h100, 16'h103, 16'h101, 16'h104, 16'h102, 16'h105};
      ew = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      #2;
      chk_reset("reset");
      fork monitor(); join_none
      tick(); tick();
      rst = 1;
      tick();
      cfg(2'b01, 16'h100, 0, 0, 0);
      tick(); tick();
      cfg(2'b00, 0, 2, 0, 1);
      cfg(2'b10, 16'h100, 0, 0, 0);
      tick(); tick();
      // conv order, ch fastest
      obs.delete();
      cfg(2'b00, 0, 2, 3, 1);
      cfg(2'b01, 16'h100, 0, 0, 0);
      run(100, 100);
      chk("conv_count", obs.size(), 6);
      for (int i = 0; i < 6 && i < obs.size(); i++) chk($sformatf("conv_addr%0d", i), obs[i], e1[i]);
      // matrix order gives a linear sweep
      obs.delete();
      cfg(2'b00, 0, 2, 3, 2);
      cfg(2'b10, 16'h10, 0, 0, 0);
      run(100, 100);
      chk("mat_count", obs.size(), 12);
      for (int i = 0; i < 12 && i < obs.size(); i++) chk($sformatf("mat_addr%0d", i), obs[i], 16'h10 + 16'(i));
      obs.delete();
      cfg(2'b00, 0, 2, 2, 2);
      cfg(2'b01, 16'h80, 0, 0, 0);
      run(70, 50);
      chk("bp_count", obs.size(), 8);
      // abort with a word parked in the output register
      obs.delete();
      cfg(2'b01, 16'h200, 0, 0, 0);
      di_valid = 1;
      do_ready = 1;
      for (int i = 0; i < 3; i++) begin
         di_data = $urandom;
         tick();
      end
      di_valid = 0;
      do_ready = 0;
      chk("pre_abort_valid", do_valid, 1);
      cfg(2'b11, 0, 0, 0, 0);
      tick(); tick();
      chk("abort_out_count", obs.size(), 2);
      obs.delete();
      cfg(2'b01, 16'h300, 0, 0, 0);
      run(100, 100);
      chk("restart_count", obs.size(), 8);
      if (obs.size() > 0) chk("restart_first", obs[0], 16'h300);
      obs.delete();
      cfg(2'b00, 0, 1, 4, 1);
      cfg(2'b10, 16'hFFFE, 0, 0, 0);
      run(100, 100);
      chk("wrap_count", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++) chk($sformatf("wrap_addr%0d", i), obs[i], ew[i]);
      for (int k = 0; k < 8; k++) begin
         cfg(2'b00, 0, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3));
         cfg(2'($urandom_range(1, 2)), 16'($urandom), 0, 0, 0);
         run($urandom_range(40, 100), $urandom_range(30, 100));
      end
      // asynchronous reset in the middle of a transfer
      cfg(2'b00, 0, 3, 3, 2);
      cfg(2'b10, 16'h500, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         di_valid = 1;
         di_data = $urandom;
         do_ready = $urandom_range(0, 1);
         tick();
      end
      rst = 0;
      #1;
      chk_reset("async");
      di_valid = 0;
      tick(); tick();
      rst = 1;
      tick();
      cfg(2'b01, 16'h500, 0, 0, 0);
      tick(); tick();
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
